// File: rtl/bp_be_trace_checker.sv
// bp_be_trace_checker
// Receiving end of the backend commit-trace stream. Each trace ROM entry is
// {opcode[3:0], payload}. The checker walks the ROM one entry at a time and
// compares the packets it accepts from the trace generator against the
// COMPARE entries.
// Build option: define BP_TRACE_CHECKER_STOP_ON_ERROR_EN to make the first
// compare mismatch halt checking in the ERROR state. Without it, a mismatch
// only sets the sticky error flag and checking continues.
module bp_be_trace_checker #(
  parameter int trace_ring_width_p     = 64,
  parameter int trace_rom_addr_width_p = 10,
  parameter int delay_width_p          = 16,
  parameter int cnt_width_p            = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              v_i,
  input  logic [trace_ring_width_p-1:0]     data_i,
  output logic                              ready_o,
  output logic [trace_rom_addr_width_p-1:0] rom_addr_o,
  input  logic [trace_ring_width_p+3:0]     rom_data_i,
  output logic                              done_o,
  output logic                              error_o,
  output logic [cnt_width_p-1:0]            pkt_cnt_o,
  output logic [cnt_width_p-1:0]            mismatch_cnt_o
);

  localparam int rom_data_width_lp = trace_ring_width_p + 4;

  localparam logic [1:0] state_run   = 2'd0;
  localparam logic [1:0] state_delay = 2'd1;
  localparam logic [1:0] state_done  = 2'd2;
  localparam logic [1:0] state_error = 2'd3;

  localparam logic [3:0] op_nop     = 4'h0;
  localparam logic [3:0] op_compare = 4'h1;
  localparam logic [3:0] op_skip    = 4'h2;
  localparam logic [3:0] op_delay   = 4'h3;
  localparam logic [3:0] op_finish  = 4'h4;

  logic [1:0]                        state_reg, state_next;
  logic [trace_rom_addr_width_p-1:0] addr_reg, addr_next;
  logic [delay_width_p-1:0]          delay_reg, delay_next;
  logic                              done_reg, done_next;
  logic                              error_reg, error_next;
  logic [cnt_width_p-1:0]            pkt_cnt_reg, pkt_cnt_next;
  logic [cnt_width_p-1:0]            mismatch_cnt_reg, mismatch_cnt_next;

  logic [3:0]                    op;
  logic [trace_ring_width_p-1:0] payload;
  logic [delay_width_p-1:0]      delay_payload;
  logic                          handshake;
  logic                          mismatch;
  logic                          advance;

  assign op            = rom_data_i[rom_data_width_lp-1 -: 4];
  assign payload       = rom_data_i[trace_ring_width_p-1:0];
  assign delay_payload = payload[delay_width_p-1:0];

  // Ready is a function of state and current opcode only (never of v_i);
  // forced low while reset is held.
  assign ready_o   = reset_n_i && (state_reg == state_run)
                     && ((op == op_compare) || (op == op_skip));
  assign handshake = v_i & ready_o;
  assign mismatch  = handshake && (op == op_compare) && (data_i != payload);

  // Next-state logic: execute the current entry or count down a delay.
  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    delay_next        = delay_reg;
    done_next         = done_reg;
    error_next        = error_reg;
    pkt_cnt_next      = pkt_cnt_reg;
    mismatch_cnt_next = mismatch_cnt_reg;
    advance           = 1'b0;

    case (state_reg)
      state_run: begin
        case (op)
          op_nop: advance = 1'b1;
          op_compare: begin
            if (handshake) begin
              if (!(&pkt_cnt_reg)) pkt_cnt_next = pkt_cnt_reg + cnt_width_p'(1);
              if (mismatch) begin
                if (!(&mismatch_cnt_reg))
                  mismatch_cnt_next = mismatch_cnt_reg + cnt_width_p'(1);
                error_next = 1'b1;
`ifdef BP_TRACE_CHECKER_STOP_ON_ERROR_EN
                state_next = state_error;
`else
                advance = 1'b1;
`endif
              end else begin
                advance = 1'b1;
              end
            end
          end
          op_skip: begin
            if (handshake) begin
              if (!(&pkt_cnt_reg)) pkt_cnt_next = pkt_cnt_reg + cnt_width_p'(1);
              advance = 1'b1;
            end
          end
          op_delay: begin
            // A zero-length delay is just a NOP.
            if (delay_payload == '0) begin
              advance = 1'b1;
            end else begin
              delay_next = delay_payload;
              state_next = state_delay;
            end
          end
          op_finish: begin
            state_next = state_done;
            done_next  = 1'b1;
          end
          default: begin
            state_next = state_error;
            error_next = 1'b1;
          end
        endcase
      end
      state_delay: begin
        // The counter holds the remaining idle cycles including this one.
        if (delay_reg <= delay_width_p'(1)) begin
          delay_next = '0;
          advance    = 1'b1;
        end else begin
          delay_next = delay_reg - delay_width_p'(1);
        end
      end
      default: begin
        // DONE and ERROR are terminal until reset.
      end
    endcase

    // Advancing past the last ROM address is an overrun, not a wrap.
    if (advance) begin
      if (&addr_reg) begin
        state_next = state_error;
        error_next = 1'b1;
      end else begin
        addr_next  = addr_reg + trace_rom_addr_width_p'(1);
        state_next = state_run;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg        <= state_run;
      addr_reg         <= '0;
      delay_reg        <= '0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      pkt_cnt_reg      <= '0;
      mismatch_cnt_reg <= '0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      delay_reg        <= delay_next;
      done_reg         <= done_next;
      error_reg        <= error_next;
      pkt_cnt_reg      <= pkt_cnt_next;
      mismatch_cnt_reg <= mismatch_cnt_next;
    end
  end

  assign rom_addr_o     = addr_reg;
  assign done_o         = done_reg;
  assign error_o        = error_reg;
  assign pkt_cnt_o      = pkt_cnt_reg;
  assign mismatch_cnt_o = mismatch_cnt_reg;

endmodule

// File: doc/bp_be_trace_checker.md
Name: bp_be_trace_checker

Overview:
- Receiving end of the backend commit-trace stream.
- Consumes packets from the trace generator over a valid/ready interface.
- Compares each packet against expected entries held in a trace ROM, sequenced by a 4-bit opcode per entry.
- Reports done, error and statistics to the testbench. Used in single- and multi-core trace demos in place of the generic FSB replay node.

Parameters:
- trace_ring_width_p, 64, packet payload width in bits.
- trace_rom_addr_width_p, 10, trace ROM address width.
- delay_width_p, 16, width of the delay counter; taken from the low bits of the payload.
- cnt_width_p, 16, width of the statistics counters.
- Derived localparam rom_data_width_lp = trace_ring_width_p+4; the opcode occupies the top 4 bits.

Ports:
- clk_i  in  1  clock; all state changes on the posedge.
- reset_n_i  in  1  synchronous, active-low reset.
- v_i  in  1  packet valid from the trace generator.
- data_i  in  trace_ring_width_p  packet payload.
- ready_o  out  1  checker accepts a packet this cycle.
- rom_addr_o  out  trace_rom_addr_width_p  registered ROM address.
- rom_data_i  in  rom_data_width_lp  combinational ROM read data for rom_addr_o.
- done_o  out  1  sticky; a FINISH entry was reached.
- error_o  out  1  sticky; a mismatch, illegal opcode or ROM overrun occurred.
- pkt_cnt_o  out  cnt_width_p  packets accepted (saturating).
- mismatch_cnt_o  out  cnt_width_p  compare failures (saturating).

Behaviour:
- Reset (reset_n_i=0 at a posedge):
  - state=RUN, rom_addr_o=0, delay counter=0.
  - done_o=0, error_o=0, pkt_cnt_o=0, mismatch_cnt_o=0.
  - ready_o=0 while reset_n_i is low.
  - Reset mid-operation discards any in-progress entry and restarts at address 0 next cycle.
- Opcodes, op = rom_data_i[top 4 bits], payload = low trace_ring_width_p bits:
  - 0x0 NOP: advance address next cycle.
  - 0x1 COMPARE: ready_o=1. On a handshake (v_i & ready_o):
    - pkt_cnt+1.
    - If data_i != payload: mismatch_cnt+1 and error_o set.
    - Advance the address.
  - 0x2 SKIP: ready_o=1. On a handshake: pkt_cnt+1, advance; data_i is ignored.
  - 0x3 DELAY: load counter with payload[delay_width_p-1:0], go to DELAY.
    - Payload 0 behaves as NOP (advance, stay in RUN).
  - 0x4 FINISH: go to DONE, done_o=1 next cycle.
  - Any other opcode: go to ERROR, error_o=1.
- States:
  - RUN: executes the current entry; one entry per cycle for NOP.
  - DELAY: ready_o=0; counter decrements each cycle; at counter==1 the address advances and the state returns to RUN (N idle cycles total for payload N).
  - DONE: terminal until reset; ready_o=0; address frozen.
  - ERROR: terminal until reset; ready_o=0.
- ready_o depends only on state and op, never on v_i (no combinational v→ready path).
- A handshake takes exactly one cycle; the next entry is visible the cycle after.
- ROM overrun: if an entry at address all-ones advances (not FINISH), go to ERROR instead of wrapping to 0.
- Counters saturate at all-ones and never wrap.
- done_o and error_o may both be 1 when a mismatch occurred earlier and FINISH was still reached.

Optional Feature:
- Macro: BP_TRACE_CHECKER_STOP_ON_ERROR_EN.
- Defined: the first COMPARE mismatch moves the FSM to ERROR on that handshake and accepts no further packets; mismatch_cnt_o stays at 1.
- Undefined: a mismatch sets sticky error_o, increments mismatch_cnt_o and checking continues to FINISH.

Test Plan:
- ROM {COMPARE 0xA5, COMPARE 0x3C, FINISH}; generator sends 0xA5 then 0x3C → pkt_cnt_o=2, mismatch_cnt_o=0, done_o=1, error_o=0.
- Same ROM, second packet 0x3D:
  - Macro off → done_o=1, error_o=1, mismatch_cnt_o=1, pkt_cnt_o=2.
  - Macro on → error_o=1, done_o=0, pkt_cnt_o=2, ready_o stays 0.
- ROM {DELAY 5, COMPARE 0x1, FINISH}; v_i held high from cycle 0 → ready_o low for exactly 5 cycles after the DELAY entry, then 1 handshake, done_o=1.
- ROM {SKIP, NOP, COMPARE 0x7, FINISH}; v_i toggled 1/0 each cycle → data on the skipped packet is ignored, no handshake while v_i=0, pkt_cnt_o=2, error_o=0.
- ROM entry 0 opcode 0xF → error_o=1 one cycle after reset release, ready_o never asserted; ROM of all COMPARE with no FINISH, run to address all-ones → ERROR, rom_addr_o does not wrap to 0.
- Assert reset_n_i=0 for one cycle mid-DELAY with error_o=1 → all outputs return to reset values and rom_addr_o=0; the run then completes cleanly.
